div_iter: RTL and testbench

Parametrised iterative integer divider for the execute stage; successor to the fixed 32-bit radix-2 divider. Performs signed or unsigned WIDTH-bit division, retiring BITS_PER_CYCLE quotient bits per clock, and returns {remainder, quotient} through the existing start/ready/annul handshake. Operands are latched at acceptance, so the pipeline may change `opdata*_i` while the divide runs. Divide-by-zero is flagged explicitly.

---
 rtl/div_if.sv | 25 ++
 rtl/div_iter.sv | 171 +++++++++++++++++
 tb/tb_div_iter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: request/response bundle for the iterative divider.
// master = execute-stage side driving operands, slave = the divider.
interface div_if #(
   parameter int WIDTH = 32
);
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 busy_o;
   logic                 div_zero_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, busy_o, div_zero_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, busy_o, div_zero_o
   );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, BITS_PER_CYCLE quotient bits per
// clock, result presented as {remainder, quotient} on a start/ready/annul
// handshake.
// Optional feature: define DIV_EARLY_OUT_EN to skip leading-zero groups of
// the dividend at acceptance (shorter latency, identical results).
//
//   state | meaning
//   IDLE  | waiting for start_i, outputs cleared
//   BUSY  | restoring iterations in progress
//   ZERO  | divisor was zero, write flagged result
//   FIX   | apply signs and write result
//   DONE  | result held until start_i drops
module div_iter #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, BUSY, ZERO, FIX, DONE} state_t;
   state_t state, state_nxt;

   logic               sgn_q, s1_q, s2_q;
   logic [WIDTH-1:0]   op1_raw_q, dvsr_q, rem_q, quo_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] result_q;
   logic               ready_q, zero_q;

   logic               s1_in, s2_in, accept, last_iter, dvd_zero;
   logic [WIDTH-1:0]   mag1, mag2, dvd_init, rem_step, quo_step, rem_fix, quo_fix;
   logic [CW-1:0]      cnt_init;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   trial;

   // operand signs and magnitudes as seen at acceptance
   always_comb begin
      s1_in = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      s2_in = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      mag1  = s1_in ? -bus.opdata1_i : bus.opdata1_i;
      mag2  = s2_in ? -bus.opdata2_i : bus.opdata2_i;
   end

`ifdef DIV_EARLY_OUT_EN
   logic [CW-1:0] lz_grp;
   logic          lz_hit;

   // count whole all-zero digit groups at the top of |op1|
   always_comb begin
      lz_grp = '0;
      lz_hit = 1'b0;
      for (int g = 0; g < N; g++) begin
         if (!lz_hit && mag1[WIDTH-1-g*BITS_PER_CYCLE -: BITS_PER_CYCLE] == '0)
            lz_grp = lz_grp + CW'(1);
         else
            lz_hit = 1'b1;
      end
   end

   assign dvd_init = mag1 << (int'(lz_grp) * BITS_PER_CYCLE);
   assign cnt_init = lz_grp;
   assign dvd_zero = (lz_grp == CW'(N));
`else
   assign dvd_init = mag1;
   assign cnt_init = '0;
   assign dvd_zero = 1'b0;
`endif

   assign accept    = (state == IDLE) && bus.start_i && !bus.annul_i;
   assign last_iter = (cnt_q == CW'(N - 1));

   // BITS_PER_CYCLE restoring steps; quo_q shifts dividend bits out, quotient bits in
   always_comb begin
      rem_step = rem_q;
      quo_step = quo_q;
      shifted  = '0;
      trial    = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         shifted  = {rem_step, quo_step[WIDTH-1]};
         trial    = {1'b0, shifted} - {2'b00, dvsr_q};
         quo_step = {quo_step[WIDTH-2:0], ~trial[WIDTH+1]};
         rem_step = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      end
   end

   // sign correction: quotient negative on sign mismatch, remainder follows dividend
   always_comb begin
      quo_fix = (sgn_q && (s1_q ^ s2_q)) ? -quo_q : quo_q;
      rem_fix = (sgn_q && s1_q) ? -rem_q : rem_q;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)
                  state_nxt = (bus.opdata2_i == '0) ? ZERO : (dvd_zero ? FIX : BUSY);
         BUSY: if (bus.annul_i)  state_nxt = IDLE;
               else if (last_iter) state_nxt = FIX;
         ZERO,
         FIX:  state_nxt = bus.annul_i ? IDLE : DONE;
         DONE: if (!bus.start_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_q     <= 1'b0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         op1_raw_q <= '0;
         dvsr_q    <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ready_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sgn_q     <= bus.signed_div_i;
               s1_q      <= s1_in;
               s2_q      <= s2_in;
               op1_raw_q <= bus.opdata1_i;
               dvsr_q    <= mag2;
               rem_q     <= '0;
               quo_q     <= dvd_init;
               cnt_q     <= cnt_init;
            end
            BUSY: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + CW'(1);
            end
            FIX: if (!bus.annul_i) begin
               result_q <= {rem_fix, quo_fix};
               ready_q  <= 1'b1;
               zero_q   <= 1'b0;
            end
            ZERO: if (!bus.annul_i) begin
               result_q <= {op1_raw_q, {WIDTH{1'b1}}};
               ready_q  <= 1'b1;
               zero_q   <= 1'b1;
            end
            DONE: if (!bus.start_i) begin
               result_q <= '0;
               ready_q  <= 1'b0;
               zero_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.result_o   = result_q;
   assign bus.ready_o    = ready_q;
   assign bus.div_zero_o = zero_q;
   assign bus.busy_o     = (state != IDLE);
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: two divider instances (32-bit/1 bit per cycle and 16-bit/2
// bits per cycle) on one clock, checked every cycle against an arithmetic
// model of the handshake (latency countdown plus plain / and %).
module tb_div_iter;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int W_OF[2]   = '{32, 16};
   localparam int BPC_OF[2] = '{1, 2};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_if #(.WIDTH(32)) bus_a ();
   div_if #(.WIDTH(16)) bus_b ();

   div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   div_iter #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   logic        t_sgn[2], t_start[2], t_annul[2];
   logic [31:0] t_a[2], t_b[2];

   assign bus_a.signed_div_i = t_sgn[0];
   assign bus_a.opdata1_i    = t_a[0];
   assign bus_a.opdata2_i    = t_b[0];
   assign bus_a.start_i      = t_start[0];
   assign bus_a.annul_i      = t_annul[0];
   assign bus_b.signed_div_i = t_sgn[1];
   assign bus_b.opdata1_i    = t_a[1][15:0];
   assign bus_b.opdata2_i    = t_b[1][15:0];
   assign bus_b.start_i      = t_start[1];
   assign bus_b.annul_i      = t_annul[1];

   logic [63:0] a_res[2];
   logic        a_rdy[2], a_busy[2], a_zero[2];
   always_comb begin
      a_res[0]  = bus_a.result_o;
      a_res[1]  = {32'h0, bus_b.result_o};
      a_rdy[0]  = bus_a.ready_o;
      a_rdy[1]  = bus_b.ready_o;
      a_busy[0] = bus_a.busy_o;
      a_busy[1] = bus_b.busy_o;
      a_zero[0] = bus_a.div_zero_o;
      a_zero[1] = bus_b.div_zero_o;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] wmask(int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // {remainder, quotient} from plain arithmetic on w-bit operands
   function automatic logic [63:0] ref_div(int w, logic sgn, logic [31:0] a_in, logic [31:0] b_in);
      logic [63:0] m, a, b, qu, ru;
      longint sa, sb, q, r;
      m = wmask(w);
      a = {32'h0, a_in} & m;
      b = {32'h0, b_in} & m;
      if (b == 0) return (a << w) | m;
      if (!sgn) begin
         qu = a / b;
         ru = a % b;
      end else begin
         sa = longint'(a);
         sb = longint'(b);
         if (a[w-1]) sa = sa - (longint'(1) << w);
         if (b[w-1]) sb = sb - (longint'(1) << w);
         if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
            q = sa;
            r = 0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
         qu = q;
         ru = r;
      end
      return ((ru & m) << w) | (qu & m);
   endfunction

   // clocks from accept edge to ready_o
   function automatic int ref_lat(int w, int bpc, logic sgn, logic [31:0] a_in, logic [31:0] b_in);
      logic [63:0] m, a, mag;
      int lz;
      m   = wmask(w);
      a   = {32'h0, a_in} & m;
      if (({32'h0, b_in} & m) == 0) return 1;
      mag = (sgn && a[w-1]) ? ((~a + 64'd1) & m) : a;
      lz  = 0;
      while (lz < w && mag[w-1-lz] == 1'b0) lz++;
      if (EARLY) return (lz == w) ? 1 : (w / bpc - lz / bpc + 1);
      return w / bpc + 1;
   endfunction

   // transaction-level model state per instance
   logic        m_act[2]   = '{1'b0, 1'b0};
   logic        m_rdy[2]   = '{1'b0, 1'b0};
   logic        m_zero[2]  = '{1'b0, 1'b0};
   logic        m_pzero[2] = '{1'b0, 1'b0};
   int          m_left[2]  = '{0, 0};
   logic [63:0] m_res[2]   = '{64'h0, 64'h0};
   logic [63:0] m_pend[2]  = '{64'h0, 64'h0};

   // advance the model on each edge, then compare every output of both DUTs
   always begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_act[d] = 1'b0; m_rdy[d] = 1'b0; m_zero[d] = 1'b0; m_res[d] = '0;
         end else if (m_rdy[d]) begin
            if (!t_start[d]) begin
               m_rdy[d] = 1'b0; m_zero[d] = 1'b0; m_res[d] = '0;
            end
         end else if (m_act[d]) begin
            if (t_annul[d]) m_act[d] = 1'b0;
            else begin
               m_left[d]--;
               if (m_left[d] == 0) begin
                  m_act[d]  = 1'b0;
                  m_rdy[d]  = 1'b1;
                  m_res[d]  = m_pend[d];
                  m_zero[d] = m_pzero[d];
               end
            end
         end else if (t_start[d] && !t_annul[d]) begin
            m_act[d]   = 1'b1;
            m_left[d]  = ref_lat(W_OF[d], BPC_OF[d], t_sgn[d], t_a[d], t_b[d]);
            m_pend[d]  = ref_div(W_OF[d], t_sgn[d], t_a[d], t_b[d]);
            m_pzero[d] = (({32'h0, t_b[d]} & wmask(W_OF[d])) == 0);
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ready%0d", d),  a_rdy[d],  m_rdy[d]);
         chk($sformatf("busy%0d", d),   a_busy[d], m_act[d] | m_rdy[d]);
         chk($sformatf("divzero%0d", d), a_zero[d], m_zero[d]);
         chk($sformatf("result%0d", d), a_res[d],  m_res[d]);
      end
   end

   // one divide: request, wait for ready (or annul), hold, release
   task automatic run_op(input int d, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int annul_at, input logic scramble,
                         output int lat, output logic [63:0] res, output logic zr);
      logic saw_rdy;
      lat     = -1;
      res     = '0;
      zr      = 1'b0;
      saw_rdy = 1'b0;
      @(negedge clk);
      t_sgn[d] = sgn; t_a[d] = a; t_b[d] = b; t_start[d] = 1'b1; t_annul[d] = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (scramble) begin
            t_a[d] = $urandom; t_b[d] = $urandom; t_sgn[d] = 1'($urandom_range(0, 1));
         end
         if (annul_at >= 0) begin
            saw_rdy = saw_rdy | a_rdy[d];
            if (k == annul_at - 1) t_annul[d] = 1'b1;
            else if (k == annul_at) begin
               t_annul[d] = 1'b0; t_start[d] = 1'b0;
            end else if (k == annul_at + 4) break;
         end else if (a_rdy[d]) begin
            lat = k;
            res = a_res[d];
            zr  = a_zero[d];
            break;
         end
      end
      if (annul_at >= 0) begin
         chk($sformatf("annul_no_ready%0d", d), saw_rdy, 1'b0);
      end else begin
         if (lat < 0) chk($sformatf("ready_timeout%0d", d), a_rdy[d], 1'b1);
         repeat (hold) begin
            @(negedge clk);
            t_annul[d] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         t_start[d] = 1'b0; t_annul[d] = 1'b0;
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] pick(int w);
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1 << (w - 1);
         4:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          lat, d, ann, hold;
      logic [63:0] res;
      logic        zr, rs;
      logic [31:0] ra, rb;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         t_sgn[i] = 1'b0; t_start[i] = 1'b0; t_annul[i] = 1'b0; t_a[i] = '0; t_b[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ready", a_rdy[0], 1'b0);
      chk("rst_busy", a_busy[0], 1'b0);
      chk("rst_result", a_res[0], 64'h0);
      rst = 1'b0;

      chk("model_100_7", ref_div(32, 1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      chk("model_m7_2", ref_div(32, 1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      chk("model_min_m1", ref_div(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});

      run_op(0, 1'b0, 32'd100, 32'd7, 2, -1, 1'b0, lat, res, zr);
      chk("res_100_7", res, {32'd2, 32'd14});
      chk("lat_100_7", lat, EARLY ? 8 : 33);
      chk("zero_100_7", zr, 1'b0);
      run_op(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1, -1, 1'b1, lat, res, zr);
      chk("res_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 1'b0, lat, res, zr);
      chk("res_min_m1", res, {32'h0, 32'h8000_0000});
      chk("zero_min_m1", zr, 1'b0);
      run_op(0, 1'b0, 32'd5, 32'd0, 3, -1, 1'b0, lat, res, zr);
      chk("res_5_0", res, {32'd5, 32'hFFFF_FFFF});
      chk("zero_5_0", zr, 1'b1);
      chk("lat_5_0", lat, 1);
      run_op(0, 1'b0, 32'd1000, 32'd3, 0, 10, 1'b1, lat, res, zr);
      run_op(0, 1'b0, 32'd9, 32'd3, 0, -1, 1'b0, lat, res, zr);
      chk("res_9_3", res, {32'd0, 32'd3});

      run_op(1, 1'b0, 32'hFFFF, 32'h1, 1, -1, 1'b0, lat, res, zr);
      chk("res16_ffff_1", res, 64'h0000_FFFF);
      chk("lat16_ffff_1", lat, 9);

      // reset in the middle of a 16-bit divide
      @(negedge clk);
      t_sgn[1] = 1'b0; t_a[1] = 32'hFFFF; t_b[1] = 32'h1; t_start[1] = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_busy16", a_busy[1], 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_ready16", a_rdy[1], 1'b0);
      chk("midrst_busy16", a_busy[1], 1'b0);
      chk("midrst_result16", a_res[1], 64'h0);
      t_start[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 1'b0, 32'd3, 32'd1, 0, -1, 1'b0, lat, res, zr);
      chk("res_3_1", res, {32'd0, 32'd3});
      chk("lat_3_1", lat, EARLY ? 3 : 33);
      run_op(0, 1'b0, 32'd0, 32'd5, 0, -1, 1'b0, lat, res, zr);
      chk("res_0_5", res, 64'h0);
      chk("lat_0_5", lat, EARLY ? 1 : 33);
      run_op(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, -1, 1'b0, lat, res, zr);
      chk("res_ffff_1", res, {32'd0, 32'hFFFF_FFFF});
      chk("lat_ffff_1", lat, 33);

      for (int i = 0; i < 70; i++) begin
         d    = (i < 40) ? 0 : 1;
         ra   = pick(W_OF[d]);
         rb   = pick(W_OF[d]);
         rs   = 1'($urandom_range(0, 1));
         hold = $urandom_range(0, 3);
         ann  = -1;
         if ($urandom_range(0, 4) == 0)
            ann = $urandom_range(1, ref_lat(W_OF[d], BPC_OF[d], rs, ra, rb));
         run_op(d, rs, ra, rb, hold, ann, 1'($urandom_range(0, 1)), lat, res, zr);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end
endmodule
